// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_pkg
// Brief    : Shared state encoding, port indices and helpers for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    localparam int WR0   = 0;
    localparam int WR1   = 1;
    localparam int RD0   = 2;
    localparam int RD1   = 3;
    localparam int LEN_W = 8;

    function automatic logic [1:0] onehot_idx(input logic [3:0] i_oh);
        onehot_idx = {i_oh[3] | i_oh[2], i_oh[3] | i_oh[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_port_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arb_if
// Brief    : Arbiter <-> SDRAM controller command/data handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface sdram_port_arb_if #(
    parameter int SDRAM_ADDRS_WIDE = 21,
    parameter int SDRAM_DATA_WIDE  = 32
);
    import sdram_arb_pkg::*;

    logic                        o_sdram_wr_req;
    logic                        o_sdram_rd_req;
    logic [SDRAM_ADDRS_WIDE-1:0] o_sdram_addrs;
    logic [LEN_W-1:0]            o_sdram_lengths;
    logic [SDRAM_DATA_WIDE-1:0]  o_sdram_wr_data;
    logic                        i_sdram_wr_data_req;
    logic                        i_sdram_data_vld;
    logic                        i_sdram_wr_done;
    logic                        i_sdram_rd_done;

    modport master (
        output o_sdram_wr_req, o_sdram_rd_req, o_sdram_addrs, o_sdram_lengths, o_sdram_wr_data,
        input  i_sdram_wr_data_req, i_sdram_data_vld, i_sdram_wr_done, i_sdram_rd_done
    );

    modport slave (
        input  o_sdram_wr_req, o_sdram_rd_req, o_sdram_addrs, o_sdram_lengths, o_sdram_wr_data,
        output i_sdram_wr_data_req, i_sdram_data_vld, i_sdram_wr_done, i_sdram_rd_done
    );

endinterface
`default_nettype wire

// File: rtl/sdram_rr_prio.sv
`default_nettype none
// ============================================================================
// Module   : sdram_rr_prio
// Brief    : Combinational winner select: urgent reads first, else round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_rr_prio
    import sdram_arb_pkg::*;
(
    input  wire logic [3:0] i_req,
    input  wire logic [3:0] i_urgent,
    input  wire logic [1:0] i_ptr,
    output logic      [3:0] o_winner
);

    localparam logic [3:0] c_URGENT_MASK = 4'b1100;

    logic [3:0] w_urgent;
    logic [1:0] w_idx;
    logic       w_found;

    assign w_urgent = i_urgent & c_URGENT_MASK;

    always_comb begin
        o_winner = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        if (i_req[RD0] && w_urgent[RD0]) begin
            o_winner[RD0] = 1'b1;
        end else if (i_req[RD1] && w_urgent[RD1]) begin
            o_winner[RD1] = 1'b1;
        end else begin
            // Scan starts at the pointer, which already points past the last winner
            for (int k = 0; k < 4; k++) begin
                w_idx = i_ptr + 2'(k);
                if (!w_found && i_req[w_idx]) begin
                    o_winner[w_idx] = 1'b1;
                    w_found         = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arb
// Brief    : Four-port (2 wr, 2 rd) SDRAM burst arbiter with urgent-read bypass.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int SDRAM_ADDRS_WIDE = 21,
    parameter int SDRAM_DATA_WIDE  = 32,
    parameter int NUM_PORT         = 4
) (
    input  wire logic                                 i_sdram_clk,
    input  wire logic                                 i_rst_n,
    input  wire logic                                 i_sdram_init_done,
    input  wire logic [NUM_PORT-1:0]                  i_port_req,
    input  wire logic [NUM_PORT-1:0]                  i_port_force,
    input  wire logic [NUM_PORT*SDRAM_ADDRS_WIDE-1:0] i_port_addrs,
    input  wire logic [NUM_PORT*LEN_W-1:0]            i_port_lengths,
    input  wire logic [2*SDRAM_DATA_WIDE-1:0]         i_port_wr_data,
    output logic      [NUM_PORT-1:0]                  o_port_done,
    output logic      [1:0]                           o_port_data_req,
    output logic      [1:0]                           o_port_data_vld,
    output logic      [NUM_PORT-1:0]                  o_port_grant,
    sdram_port_arb_if.master                          bus
);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [NUM_PORT-1:0]         r_grant;
    logic [1:0]                  r_ptr;
    logic [SDRAM_ADDRS_WIDE-1:0] r_addrs;
    logic [LEN_W-1:0]            r_len;
    logic [NUM_PORT-1:0]         w_winner;
    logic [1:0]                  w_win_idx;
    logic                        w_arb_ok;
    logic                        w_grant_wr;
    logic                        w_grant_rd;
    logic                        w_done_hit;

    sdram_rr_prio u_prio (
        .i_req    (i_port_req),
        .i_urgent (i_port_force),
        .i_ptr    (r_ptr),
        .o_winner (w_winner)
    );

    assign w_win_idx  = onehot_idx(w_winner);
    assign w_arb_ok   = i_sdram_init_done && (w_winner != '0);
    assign w_grant_wr = r_grant[WR0] | r_grant[WR1];
    assign w_grant_rd = r_grant[RD0] | r_grant[RD1];

    always_ff @(posedge i_sdram_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_hit  = 1'b0;
        case (r_state)
            ST_IDLE: if (i_sdram_init_done && (i_port_req != '0)) w_state_nxt = ST_ARB;
            ST_ARB:  w_state_nxt = w_arb_ok ? ST_BUSY : ST_IDLE;
            ST_BUSY: begin
                // Loss of init aborts silently; a done of the other type is ignored
                if (!i_sdram_init_done) begin
                    w_state_nxt = ST_IDLE;
                end else if ((w_grant_wr && bus.i_sdram_wr_done) ||
                             (w_grant_rd && bus.i_sdram_rd_done)) begin
                    w_done_hit  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        bus.o_sdram_wr_req = (r_state == ST_BUSY) && w_grant_wr;
        bus.o_sdram_rd_req = (r_state == ST_BUSY) && w_grant_rd;
        o_port_done        = w_done_hit ? r_grant : '0;
    end

    always_ff @(posedge i_sdram_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant <= '0;
            r_ptr   <= '0;
            r_addrs <= '0;
            r_len   <= '0;
        end else begin
            case (r_state)
                ST_ARB: if (w_arb_ok) begin
                    r_grant <= w_winner;
                    r_addrs <= i_port_addrs[int'(w_win_idx)*SDRAM_ADDRS_WIDE +: SDRAM_ADDRS_WIDE];
                    r_len   <= i_port_lengths[int'(w_win_idx)*LEN_W +: LEN_W];
                end
                ST_BUSY: begin
                    if (!i_sdram_init_done) begin
                        r_grant <= '0;
                    end else if (w_done_hit) begin
                        r_grant <= '0;
                        r_ptr   <= onehot_idx(r_grant) + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_port_grant        = r_grant;
    assign bus.o_sdram_addrs   = r_addrs;
    assign bus.o_sdram_lengths = r_len;
    assign bus.o_sdram_wr_data = r_grant[WR1] ? i_port_wr_data[SDRAM_DATA_WIDE +: SDRAM_DATA_WIDE] :
                                 r_grant[WR0] ? i_port_wr_data[0 +: SDRAM_DATA_WIDE] : '0;
    assign o_port_data_req     = r_grant[WR1:WR0] & {2{bus.i_sdram_wr_data_req}};
    assign o_port_data_vld     = r_grant[RD1:RD0] & {2{bus.i_sdram_data_vld}};

endmodule
`default_nettype wire
